pool_scheduler: RTL and testbench
=================================

POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of conv channels sharing one maxpool engine (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in WAIT.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NUM_CH  per-channel "ofmap ready for pooling", level, held until ack.
REQ-006 SHALL have port ack  output  NUM_CH  one-cycle one-hot job-complete pulse to the granted channel.
REQ-007 SHALL have port sel_ch  output  $clog2(NUM_CH)  granted channel index, drives the external ifmap mux.
REQ-008 SHALL have port pool_rst  output  1  active-high reset to the maxpool engine.
REQ-009 SHALL have port pool_en  output  1  one-cycle start pulse to the maxpool engine.
REQ-010 SHALL have port done_pool  input  1  engine completion level (sticky while engine in DONE).
REQ-011 SHALL have port wr_en  output  1  one-cycle strobe to latch pooled ofmap into the channel-wr_ch output buffer.
REQ-012 SHALL have port wr_ch  output  $clog2(NUM_CH)  buffer index for wr_en; equals sel_ch.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port job_count  output  16  completed jobs, saturating at 0xFFFF.
REQ-015 SHALL have port err  output  1  sticky watchdog-timeout flag.

Function
REQ-016 FSM states IDLE, CLEAR, START, WAIT, WRITE (plus ABORT when POOL_SCHED_TIMEOUT_EN); all registered outputs.
REQ-017 IDLE: if any req bit high, SHALL register round-robin grant into sel_ch and go CLEAR; else stay.
REQ-018 Round-robin: priority starts at channel 0 after reset; after granting i, highest priority becomes (i+1) mod NUM_CH.
REQ-019 CLEAR: pool_rst=1 for exactly one cycle, then START; pool_rst=0 in all other non-reset states.
REQ-020 START: pool_en=1 for exactly one cycle, then WAIT.
REQ-021 WAIT: pool_en=0; on done_pool=1 go WRITE; done_pool in CLEAR/START SHALL be ignored (stale).
REQ-022 WRITE: wr_en=1 and ack[sel_ch]=1 for one cycle, job_count+1 (saturating), then IDLE.
REQ-023 Minimum req-to-ack latency: 4 cycles plus engine time (IDLE grant edge, CLEAR, START, WAIT>=1, WRITE).
REQ-024 req deasserting mid-job SHALL be ignored; job completes and ack still pulses.
REQ-025 Requests arriving while busy SHALL wait; no grant change until return to IDLE.
REQ-026 A channel whose req stays high after its ack is eligible again only under round-robin order.
REQ-027 sel_ch/wr_ch SHALL remain stable from CLEAR through WRITE.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, ack=0, pool_en=0, wr_en=0, busy=0, sel_ch=0, wr_ch=0, job_count=0, err=0, RR pointer=0, pool_rst=1.
REQ-029 pool_rst SHALL drop to 0 on first clock in IDLE after reset release.
REQ-030 Reset mid-job SHALL abandon the job without ack or wr_en; channel must re-request.

Configuration
REQ-031 Macro POOL_SCHED_TIMEOUT_EN defined: counter clears on WAIT entry; at TIMEOUT_CYCLES cycles in WAIT without done_pool go ABORT: err=1 (sticky), ack[sel_ch]=1 one cycle, wr_en=0, job_count unchanged, then IDLE.
REQ-032 Macro undefined: no counter, no ABORT state, WAIT unbounded, err tied 0.

Verification
REQ-033 Single req[2]=1, engine done 10 cycles after pool_en -> pool_rst, pool_en, wr_en/ack[2] in order; sel_ch=2; job_count=1.
REQ-034 req=4'b1111 held, NUM_CH=4 -> grants 0,1,2,3,0 in order; each ack one-hot single cycle.
REQ-035 done_pool held high from previous job -> no early WRITE; WRITE only after done_pool after START.
REQ-036 reset_n low during WAIT -> all outputs at REQ-028 values immediately; no ack; next job starts from channel 0.
REQ-037 Macro defined, TIMEOUT_CYCLES=16, done_pool never rises -> ABORT after 16 WAIT cycles, err=1, ack pulse, wr_en=0, job_count unchanged.
REQ-038 Force job_count=0xFFFF then complete job -> stays 0xFFFF.

Source files
------------

// File: rtl/pool_scheduler.sv
// Round-robin scheduler sharing one maxpool engine among NUM_CH conv channels.
// Optional watchdog/ABORT path enabled by defining POOL_SCHED_TIMEOUT_EN.
module pool_scheduler #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         req,
    output logic [NUM_CH-1:0]         ack,
    output logic [$clog2(NUM_CH)-1:0] sel_ch,
    output logic                      pool_rst,
    output logic                      pool_en,
    input  logic                      done_pool,
    output logic                      wr_en,
    output logic [$clog2(NUM_CH)-1:0] wr_ch,
    output logic                      busy,
    output logic [15:0]               job_count,
    output logic                      err
);

    localparam int unsigned CW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pool_scheduler: parameter out of range");
    end

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {StIdle, StClear, StStart, StWait, StWrite, StAbort} state_e;
`else
    typedef enum logic [2:0] {StIdle, StClear, StStart, StWait, StWrite} state_e;
`endif

    state_e            r_state;
    logic [CW-1:0]     r_sel_ch;
    logic [CW-1:0]     r_rr_ptr;
    logic [NUM_CH-1:0] r_ack;
    logic              r_pool_rst;
    logic              r_pool_en;
    logic              r_wr_en;
    logic              r_busy;
    logic [15:0]       r_job_count;
`ifdef POOL_SCHED_TIMEOUT_EN
    logic              r_err;
    logic [TW-1:0]     r_wd_cnt;
`endif

    logic [CW:0]       w_idx;
    logic [CW-1:0]     w_grant;
    logic [CW-1:0]     w_next_ptr;
    logic [NUM_CH-1:0] w_sel_onehot;

    // Scan downward from the lowest priority so the highest-priority requester wins last.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (CW+1)'(k);
            if (w_idx >= (CW+1)'(NUM_CH)) begin
                w_idx = w_idx - (CW+1)'(NUM_CH);
            end
            if (req[w_idx[CW-1:0]]) begin
                w_grant = w_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        w_next_ptr = (w_grant == CW'(NUM_CH - 1)) ? '0 : w_grant + CW'(1);
    end

    always_comb begin
        w_sel_onehot           = '0;
        w_sel_onehot[r_sel_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_sel_ch    <= '0;
            r_rr_ptr    <= '0;
            r_ack       <= '0;
            r_pool_rst  <= 1'b1;
            r_pool_en   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_job_count <= '0;
`ifdef POOL_SCHED_TIMEOUT_EN
            r_err       <= 1'b0;
            r_wd_cnt    <= '0;
`endif
        end else begin
            r_ack      <= '0;
            r_pool_rst <= 1'b0;
            r_pool_en  <= 1'b0;
            r_wr_en    <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (|req) begin
                        r_sel_ch   <= w_grant;
                        r_rr_ptr   <= w_next_ptr;
                        r_pool_rst <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= StClear;
                    end
                end
                StClear: begin
                    r_pool_en <= 1'b1;
                    r_state   <= StStart;
                end
                StStart: begin
`ifdef POOL_SCHED_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                    r_state  <= StWait;
                end
                StWait: begin
                    // done_pool is only trusted here; earlier it may be left over from the last job.
                    if (done_pool) begin
                        r_wr_en <= 1'b1;
                        r_ack   <= w_sel_onehot;
                        if (r_job_count != 16'hFFFF) begin
                            r_job_count <= r_job_count + 16'd1;
                        end
                        r_state <= StWrite;
                    end
`ifdef POOL_SCHED_TIMEOUT_EN
                    else if (r_wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_ack   <= w_sel_onehot;
                        r_err   <= 1'b1;
                        r_state <= StAbort;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + TW'(1);
                    end
`endif
                end
                StWrite: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
`ifdef POOL_SCHED_TIMEOUT_EN
                StAbort: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign sel_ch    = r_sel_ch;
    assign wr_ch     = r_sel_ch;
    assign pool_rst  = r_pool_rst;
    assign pool_en   = r_pool_en;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign job_count = r_job_count;
`ifdef POOL_SCHED_TIMEOUT_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pool_scheduler.sv
// Self-checking bench for pool_scheduler: randomized jobs against a transaction-level model.
module tb_pool_scheduler;

    localparam int NC = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NC-1:0] req = '0;
    logic [NC-1:0] ack;
    logic [1:0]    sel_ch;
    logic [1:0]    wr_ch;
    logic          pool_rst;
    logic          pool_en;
    logic          done_pool;
    logic          wr_en;
    logic          busy;
    logic [15:0]   job_count;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_ptr   = 0;
    int jc_model = 0;

    // Simple engine: start on pool_en, done after eng_lat cycles, sticky until pool_rst.
    logic eng_done = 1'b0;
    int   eng_cnt  = 0;
    bit   eng_run  = 1'b0;
    int   eng_lat  = 4;
    bit   manual   = 1'b0;
    logic man_done = 1'b0;

    assign done_pool = manual ? man_done : eng_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pool_rst) begin
            eng_done <= 1'b0;
            eng_run  <= 1'b0;
            eng_cnt  <= 0;
        end else if (pool_en) begin
            eng_run <= 1'b1;
            eng_cnt <= eng_lat;
        end else if (eng_run) begin
            if (eng_cnt <= 1) begin
                eng_done <= 1'b1;
                eng_run  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    pool_scheduler #(
        .NUM_CH         (NC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .ack       (ack),
        .sel_ch    (sel_ch),
        .pool_rst  (pool_rst),
        .pool_en   (pool_en),
        .done_pool (done_pool),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .busy      (busy),
        .job_count (job_count),
        .err       (err)
    );

    function automatic int predict(input logic [NC-1:0] r, input int ptr);
        for (int k = 0; k < NC; k++) begin
            int idx = (ptr + k) % NC;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NC-1:0] onehot(input int ch);
        logic [NC-1:0] one = 1;
        return one << ch;
    endfunction

    // Observes one job from the IDLE negedge; returns what it saw, compares nothing.
    task automatic wait_job(input int budget, input bit drop_mid, input logic [NC-1:0] add_mid,
                            output int ch, output logic [NC-1:0] ack_v, output int wr_ch_v,
                            output int jc, output int wait_cycles, output bit seq_ok,
                            output bit timed_out, output bit aborted);
        int n;
        ch = -1; ack_v = '0; wr_ch_v = -1; jc = -1; wait_cycles = 0;
        seq_ok = 1'b1; timed_out = 1'b0; aborted = 1'b0;
        n = 0;
        while (!(busy && pool_rst) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(busy && pool_rst)) begin
            timed_out = 1'b1;
            return;
        end
        ch = int'(sel_ch);
        if (pool_en || wr_en || ack != '0) seq_ok = 1'b0;
        if (drop_mid) req = '0;
        req = req | add_mid;
        @(negedge clk);
        if (!pool_en || pool_rst || wr_en || ack != '0 || int'(sel_ch) != ch) seq_ok = 1'b0;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (wr_en || ack != '0) break;
            if (pool_en || pool_rst || !busy || int'(sel_ch) != ch) seq_ok = 1'b0;
        end
        if (!(wr_en || ack != '0)) begin
            timed_out = 1'b1;
            return;
        end
        wait_cycles = n;
        ack_v       = ack;
        wr_ch_v     = int'(wr_ch);
        jc          = int'(job_count);
        aborted     = !wr_en;
        if (int'(sel_ch) != ch || pool_en || pool_rst) seq_ok = 1'b0;
        @(negedge clk);
        if (busy || wr_en || ack != '0 || pool_en) seq_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req     = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, pool_en, wr_en, err, pool_rst} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00001", {busy, pool_en, wr_en, err, pool_rst});
        end
        n_checks++;
        if ({ack, sel_ch, wr_ch} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ack_sel: got %h want 00", {ack, sel_ch, wr_ch});
        end
        n_checks++;
        if (job_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_job_count: got %h want 0000", job_count);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pool_rst, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 00", {pool_rst, busy});
        end
        rr_ptr   = 0;
        jc_model = 0;
    endtask

    task automatic test_single;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab;
        eng_lat = 10;
        req     = 4'b0100;
        exp     = predict(req, rr_ptr);
        rr_ptr  = (exp + 1) % NC;
        jc_model++;
        wait_job(100, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
        req = '0;
        n_checks++;
        if (!ok || to) begin
            n_fail++;
            $display("FAIL single_seq: got ok=%0d timeout=%0d want ok=1 timeout=0", ok, to);
        end
        n_checks++;
        if (ch !== 2 || wrc !== 2) begin
            n_fail++;
            $display("FAIL single_sel: got sel=%0d wr_ch=%0d want 2", ch, wrc);
        end
        n_checks++;
        if (av !== 4'b0100 || ab) begin
            n_fail++;
            $display("FAIL single_ack: got %b want 0100", av);
        end
        n_checks++;
        if (jc !== 1) begin
            n_fail++;
            $display("FAIL single_job_count: got %0d want 1", jc);
        end
        n_checks++;
        if (wc !== 12) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want 12", wc);
        end
    endtask

    task automatic test_round_robin;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        rr_ptr   = 0;
        jc_model = 0;
        @(negedge clk);
        req = '1;
        for (int i = 0; i < 5; i++) begin
            eng_lat = int'($urandom_range(1, 6));
            exp     = predict(req, rr_ptr);
            rr_ptr  = (exp + 1) % NC;
            jc_model++;
            wait_job(100, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
            n_checks++;
            if (ch !== exp || ch !== i % NC) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %0d want %0d", i, ch, i % NC);
            end
            n_checks++;
            if (av !== onehot(exp) || !ok || to) begin
                n_fail++;
                $display("FAIL rr_ack[%0d]: got %b ok=%0d want %b ok=1", i, av, ok, onehot(exp));
            end
            n_checks++;
            if (jc !== jc_model) begin
                n_fail++;
                $display("FAIL rr_job_count[%0d]: got %0d want %0d", i, jc, jc_model);
            end
        end
        req = '0;
    endtask

    task automatic test_random;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av, add;
        bit ok, to, ab, drop;
        for (int i = 0; i < 20; i++) begin
            req     = req | NC'($urandom_range(1, (1 << NC) - 1));
            drop    = ($urandom_range(0, 3) == 0);
            add     = NC'($urandom);
            eng_lat = int'($urandom_range(1, 8));
            exp     = predict(req, rr_ptr);
            rr_ptr  = (exp + 1) % NC;
            if (jc_model < 65535) jc_model++;
            wait_job(100, drop, add, ch, av, wrc, jc, wc, ok, to, ab);
            req[exp] = 1'b0;
            n_checks++;
            if (ch !== exp || wrc !== exp) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got sel=%0d wr_ch=%0d want %0d", i, ch, wrc, exp);
            end
            n_checks++;
            if (av !== onehot(exp) || ab) begin
                n_fail++;
                $display("FAIL rand_ack[%0d]: got %b want %b", i, av, onehot(exp));
            end
            n_checks++;
            if (!ok || to) begin
                n_fail++;
                $display("FAIL rand_seq[%0d]: got ok=%0d timeout=%0d want 1 0", i, ok, to);
            end
            n_checks++;
            if (jc !== jc_model) begin
                n_fail++;
                $display("FAIL rand_job_count[%0d]: got %0d want %0d", i, jc, jc_model);
            end
            n_checks++;
            if (wc !== eng_lat + 2) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", i, wc, eng_lat + 2);
            end
        end
        req = '0;
    endtask

    task automatic test_stale_done;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab;
        eng_lat  = 20;
        manual   = 1'b1;
        man_done = 1'b1;
        req      = 4'b0001;
        exp      = predict(req, rr_ptr);
        rr_ptr   = (exp + 1) % NC;
        if (jc_model < 65535) jc_model++;
        fork
            wait_job(100, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
            begin
                int n = 0;
                while (!pool_en && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                man_done = 1'b0;
                repeat (5) @(negedge clk);
                man_done = 1'b1;
            end
        join
        req      = '0;
        manual   = 1'b0;
        man_done = 1'b0;
        n_checks++;
        if (!ok || to) begin
            n_fail++;
            $display("FAIL stale_seq: got ok=%0d timeout=%0d want 1 0", ok, to);
        end
        n_checks++;
        if (wc !== 7) begin
            n_fail++;
            $display("FAIL stale_latency: got %0d want 7", wc);
        end
        n_checks++;
        if (ch !== exp || av !== onehot(exp) || jc !== jc_model) begin
            n_fail++;
            $display("FAIL stale_result: got ch=%0d ack=%b jc=%0d want %0d %b %0d",
                     ch, av, jc, exp, onehot(exp), jc_model);
        end
    endtask

    task automatic test_reset_mid;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab, bad;
        eng_lat = 40;
        req     = 4'b0010;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, pool_rst, pool_en, wr_en, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got %b want 01000", {busy, pool_rst, pool_en, wr_en, err});
        end
        n_checks++;
        if ({ack, sel_ch, wr_ch} !== 8'h00 || job_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_vals: got %h jc=%h want 00 0000", {ack, sel_ch, wr_ch}, job_count);
        end
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack != '0 || wr_en) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_ack: got %0d want 0", bad);
        end
        rr_ptr   = 0;
        jc_model = 0;
        req      = '1;
        reset_n  = 1'b1;
        eng_lat  = 3;
        exp      = predict(req, rr_ptr);
        rr_ptr   = (exp + 1) % NC;
        jc_model++;
        wait_job(100, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
        req = '0;
        n_checks++;
        if (ch !== 0 || av !== onehot(0) || jc !== jc_model || !ok) begin
            n_fail++;
            $display("FAIL rstmid_restart: got ch=%0d ack=%b jc=%0d want 0 0001 %0d",
                     ch, av, jc, jc_model);
        end
    endtask

    task automatic test_saturate;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab;
        force dut.r_job_count = 16'hFFFF;
        #1;
        release dut.r_job_count;
        jc_model = 65535;
        eng_lat  = 3;
        req      = 4'b1000;
        exp      = predict(req, rr_ptr);
        rr_ptr   = (exp + 1) % NC;
        wait_job(100, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
        req = '0;
        n_checks++;
        if (jc !== jc_model || av !== onehot(exp)) begin
            n_fail++;
            $display("FAIL sat_write: got jc=%0d ack=%b want %0d %b", jc, av, jc_model, onehot(exp));
        end
        @(negedge clk);
        n_checks++;
        if (job_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h want ffff", job_count);
        end
    endtask

`ifdef POOL_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab;
        manual   = 1'b1;
        man_done = 1'b0;
        req      = 4'b0100;
        exp      = predict(req, rr_ptr);
        rr_ptr   = (exp + 1) % NC;
        wait_job(200, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
        req    = '0;
        manual = 1'b0;
        n_checks++;
        if (!ab || to || av !== onehot(exp) || ch !== exp) begin
            n_fail++;
            $display("FAIL timeout_abort: got abort=%0d ack=%b want 1 %b", ab, av, onehot(exp));
        end
        n_checks++;
        if (wc !== TO + 1) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d want %0d", wc, TO + 1);
        end
        n_checks++;
        if (jc !== jc_model) begin
            n_fail++;
            $display("FAIL timeout_job_count: got %0d want %0d", jc, jc_model);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err_sticky: got %b want 1", err);
        end
    endtask
`else
    task automatic test_unbounded_wait;
        int ch, wc, jc, wrc, exp;
        logic [NC-1:0] av;
        bit ok, to, ab;
        manual   = 1'b1;
        man_done = 1'b0;
        req      = 4'b0100;
        exp      = predict(req, rr_ptr);
        rr_ptr   = (exp + 1) % NC;
        if (jc_model < 65535) jc_model++;
        fork
            wait_job(200, 1'b0, '0, ch, av, wrc, jc, wc, ok, to, ab);
            begin
                repeat (60) @(negedge clk);
                man_done = 1'b1;
            end
        join
        req      = '0;
        manual   = 1'b0;
        man_done = 1'b0;
        n_checks++;
        if (ab || to || !ok || wc !== 59) begin
            n_fail++;
            $display("FAIL unbounded_wait: got abort=%0d ok=%0d cycles=%0d want 0 1 59", ab, ok, wc);
        end
        n_checks++;
        if (err !== 1'b0 || av !== onehot(exp) || jc !== jc_model) begin
            n_fail++;
            $display("FAIL unbounded_result: got err=%b ack=%b jc=%0d want 0 %b %0d",
                     err, av, jc, onehot(exp), jc_model);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test want end before 500000");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_stale_done();
        test_reset_mid();
        test_saturate();
`ifdef POOL_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
